mul_hilo_ctrl: RTL and testbench

MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

---
 rtl/mul_hilo_ctrl.sv | 95 +++++++++
 tb/tb_mul_hilo_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl.sv
// Sequences an external shift-add multiplier (clear, MUL_CYCLES x MULTU, OUT) and captures the 64-bit product into HI/LO.
// Latency: start at edge k -> HI/LO and done valid from edge k+35; starts while busy are dropped.
module mul_hilo_ctrl #(
  parameter logic [5:0] MULTU      = 6'b011001,
  parameter logic [5:0] OUT        = 6'b111111,
  parameter logic [5:0] MFHI       = 6'b010000,
  parameter logic [5:0] MFLO       = 6'b010010,
  parameter int         MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  readSel,
  output logic [31:0] mulA,
  output logic [31:0] mulB,
  output logic [5:0]  mulSignal,
  output logic        mulReset,
  input  logic [63:0] mulProduct,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST = 6'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, OUTPUT, CAPTURE} state_t;

  state_t      state;
  logic [5:0]  counter;
  logic [31:0] opA, opB, hi, lo;
  logic        drive_ops;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 6'd0;
      opA     <= 32'd0;
      opB     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      dataOut <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opA   <= dataA;
            opB   <= dataB;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          counter <= 6'd0;
          state   <= RUN;
        end
        RUN: begin
          // Counter parks at LAST rather than wrapping; CLEAR rezeroes it.
          if (counter == LAST) state <= OUTPUT;
          else                 counter <= counter + 6'd1;
        end
        OUTPUT: state <= CAPTURE;
        CAPTURE: begin
          hi    <= mulProduct[63:32];
          lo    <= mulProduct[31:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Reads see the pre-update HI/LO at the capture edge.
      if (readSel == MFHI)      dataOut <= hi;
      else if (readSel == MFLO) dataOut <= lo;
    end
  end

  // Operands drop to zero in IDLE/CAPTURE so repeated identical operands still toggle.
  assign drive_ops = (state == CLEAR) || (state == RUN) || (state == OUTPUT);
  assign mulA      = drive_ops ? opA : 32'd0;
  assign mulB      = drive_ops ? opB : 32'd0;
  assign mulReset  = (state == CLEAR);
  assign busy      = (state != IDLE);

  always_comb begin
    mulSignal = 6'b000000;
    case (state)
      RUN:     mulSignal = MULTU;
      OUTPUT:  mulSignal = OUT;
      default: mulSignal = 6'b000000;
    endcase
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural multiplier that yields mulA*mulB on the OUT opcode.
module tb_mul_hilo_ctrl;

  localparam logic [5:0] MULTU_OP = 6'b011001;
  localparam logic [5:0] OUT_OP   = 6'b111111;
  localparam logic [5:0] MFHI_OP  = 6'b010000;
  localparam logic [5:0] MFLO_OP  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dataA, dataB;
  logic [5:0]  readSel;
  logic [31:0] mulA, mulB;
  logic [5:0]  mulSignal;
  logic        mulReset;
  logic [63:0] mulProduct;
  logic [31:0] dataOut;
  logic        busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  mul_hilo_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .readSel(readSel), .mulA(mulA), .mulB(mulB), .mulSignal(mulSignal),
    .mulReset(mulReset), .mulProduct(mulProduct), .dataOut(dataOut),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: cleared by mulReset, produces the full product on OUT.
  always @(posedge clk) begin
    if (reset || mulReset)    mulProduct <= 64'd0;
    else if (mulSignal == OUT_OP) mulProduct <= {32'd0, mulA} * {32'd0, mulB};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [5:0] sel, output logic [31:0] val);
    readSel = sel;
    tick();
    val = dataOut;
    readSel = 6'd0;
  endtask

  // Issues one start then watches 40 cycles; j counts cycles after the accepting edge.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit inj,
                        output int busy_n, output int multu_n, output int out_n,
                        output int clr_n, output int done_n, output int done_at);
    busy_n = 0; multu_n = 0; out_n = 0; clr_n = 0; done_n = 0; done_at = -1;
    dataA = a; dataB = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (busy) busy_n++;
      if (mulSignal == MULTU_OP) multu_n++;
      if (mulSignal == OUT_OP) out_n++;
      if (mulReset) clr_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (inj && (j == 5 || j == 20)) begin
        start = 1'b1; dataA = 32'd100; dataB = 32'd100;
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  int bn, mn, on, cn, dn, da;
  logic [31:0] v;
  bit seen;

  initial begin
    reset = 1'b1; start = 1'b0; dataA = '0; dataB = '0; readSel = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", mulSignal, 0);
    chk("rst_mulA", mulA, 0);
    chk("rst_mulReset", mulReset, 0);
    rd(MFHI_OP, v); chk("rst_hi", v, 0);
    rd(MFLO_OP, v); chk("rst_lo", v, 0);

    // 3 * 5
    do_mul(32'd3, 32'd5, 1'b0, bn, mn, on, cn, dn, da);
    chk("a_busy_cycles", bn, 35);
    chk("a_done_at", da, 35);
    chk("a_done_cnt", dn, 1);
    chk("a_clear_cnt", cn, 1);
    rd(MFLO_OP, v); chk("a_lo", v, 32'h0000000F);
    rd(MFHI_OP, v); chk("a_hi", v, 32'h00000000);

    // Max operands
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, bn, mn, on, cn, dn, da);
    chk("b_multu_cycles", mn, 32);
    chk("b_out_cycles", on, 1);
    rd(MFHI_OP, v); chk("b_hi", v, 32'hFFFFFFFE);
    rd(MFLO_OP, v); chk("b_lo", v, 32'h00000001);

    // Back-to-back 7*9, second start in the done cycle; LO read held throughout
    readSel = MFLO_OP;
    dataA = 32'd7; dataB = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 50 && !seen; j++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk("c_done_seen", seen, 1);
    chk("c_read_at_capture", dataOut, 32'h00000001);
    chk("c_mulA_idle", mulA, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c_second_busy", busy, 1);
    chk("c_first_lo", dataOut, 32'h0000003F);
    seen = 1'b0;
    for (int j = 0; j < 50 && !seen; j++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk("c2_done_seen", seen, 1);
    tick();
    readSel = 6'd0;
    rd(MFLO_OP, v); chk("c2_lo", v, 32'h0000003F);
    rd(MFHI_OP, v); chk("c2_hi", v, 32'h00000000);

    // Zero operand
    do_mul(32'd7, 32'd0, 1'b0, bn, mn, on, cn, dn, da);
    rd(MFLO_OP, v); chk("z_lo", v, 0);
    rd(MFHI_OP, v); chk("z_hi", v, 0);

    // Starts injected mid-operation must be ignored
    do_mul(32'd6, 32'd7, 1'b1, bn, mn, on, cn, dn, da);
    chk("d_busy_cycles", bn, 35);
    chk("d_done_cnt", dn, 1);
    chk("d_clear_cnt", cn, 1);
    rd(MFLO_OP, v); chk("d_lo", v, 32'h0000002A);

    // Reset mid-RUN after a 0x3F result
    do_mul(32'd7, 32'd9, 1'b0, bn, mn, on, cn, dn, da);
    rd(MFLO_OP, v); chk("e_prior_lo", v, 32'h0000003F);
    dataA = 32'd5; dataB = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("e_in_run", mulSignal, MULTU_OP);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("e_busy", busy, 0);
    chk("e_sig", mulSignal, 0);
    chk("e_dataOut", dataOut, 0);
    dn = 0;
    for (int j = 0; j < 40; j++) begin
      if (done) dn++;
      tick();
    end
    chk("e_no_done", dn, 0);
    rd(MFHI_OP, v); chk("e_hi", v, 0);
    rd(MFLO_OP, v); chk("e_lo", v, 0);
    do_mul(32'd2, 32'd2, 1'b0, bn, mn, on, cn, dn, da);
    chk("e_done_at", da, 35);
    rd(MFLO_OP, v); chk("e_lo_after", v, 32'h00000004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
